// File: rtl/box_plotter_pkg.sv
// Shared definitions for the box plotter and the arrow-drawing logic that feeds it.
package box_plotter_pkg;

  // Plotter controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Visible screen area of the VGA adapter
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  // Scan counters cover box sizes up to 16x16
  localparam int CNT_W = 4;

  // Arrow anchor coordinates (top-left corner of each arrow box)
  localparam logic [7:0] UP_X    = 8'd78;
  localparam logic [6:0] UP_Y    = 7'd54;
  localparam logic [7:0] DOWN_X  = 8'd78;
  localparam logic [6:0] DOWN_Y  = 7'd62;
  localparam logic [7:0] LEFT_X  = 8'd74;
  localparam logic [6:0] LEFT_Y  = 7'd58;
  localparam logic [7:0] RIGHT_X = 8'd82;
  localparam logic [6:0] RIGHT_Y = 7'd58;

  // Fill colours
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/box_scan_counter.sv
// Row-major scan counter over a BOX_W x BOX_H box; exposes the following
// position so the plotter can register the next pixel ahead of time.
module box_scan_counter
  import box_plotter_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] next_cx,
  output logic [CNT_W-1:0] next_cy,
  output logic             last
);

  logic [CNT_W-1:0] cx;
  logic [CNT_W-1:0] cy;
  logic             row_end;

  assign row_end = (cx == CNT_W'(BOX_W - 1));
  assign last    = row_end && (cy == CNT_W'(BOX_H - 1));
  assign next_cx = row_end ? '0 : cx + CNT_W'(1);
  assign next_cy = row_end ? cy + CNT_W'(1) : cy;

  // Restart at the top-left on a new box, otherwise step one pixel when told to
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      cx <= next_cx;
      cy <= next_cy;
    end
  end

endmodule

// File: rtl/box_plotter.sv
// Accepts one box request per handshake and streams its pixels, one per
// cycle, to the VGA adapter write port, clipping anything off-screen.
module box_plotter #(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3,
  parameter int SCR_W = box_plotter_pkg::SCR_W,
  parameter int SCR_H = box_plotter_pkg::SCR_H
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [C_W-1:0] req_color,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  import box_plotter_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [X_W-1:0]   bx;
  logic [Y_W-1:0]   by;
  logic [C_W-1:0]   col;
  logic [CNT_W-1:0] next_cx;
  logic [CNT_W-1:0] next_cy;
  logic             last;
  logic             accept;
  logic             advance;

  logic [X_W-1:0]   src_x;
  logic [Y_W-1:0]   src_y;
  logic [C_W-1:0]   src_c;
  logic [CNT_W-1:0] off_x;
  logic [CNT_W-1:0] off_y;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic             in_bounds;

  logic [X_W-1:0]   x_nxt;
  logic [Y_W-1:0]   y_nxt;
  logic [C_W-1:0]   c_nxt;
  logic             plot_nxt;
  logic             done_nxt;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign advance   = (state == DRAW) && !last;

  box_scan_counter #(
    .BOX_W(BOX_W),
    .BOX_H(BOX_H)
  ) u_scan (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (accept),
    .advance(advance),
    .next_cx(next_cx),
    .next_cy(next_cy),
    .last   (last)
  );

  // Pixel about to be loaded: pixel 0 straight from the request, else the next scan position
  always_comb begin
    src_x = bx;
    src_y = by;
    src_c = col;
    off_x = next_cx;
    off_y = next_cy;
    if (state == IDLE) begin
      src_x = req_x;
      src_y = req_y;
      src_c = req_color;
      off_x = '0;
      off_y = '0;
    end
  end

  assign sum_x     = {1'b0, src_x} + (X_W + 1)'(off_x);
  assign sum_y     = {1'b0, src_y} + (Y_W + 1)'(off_y);
  assign in_bounds = (int'(sum_x) < SCR_W) && (int'(sum_y) < SCR_H);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept, draw every pixel, spend one cycle signalling done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRAW;
      DRAW:    if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the adapter outputs; coordinates hold whenever nothing is plotted
  always_comb begin
    x_nxt    = vga_x;
    y_nxt    = vga_y;
    c_nxt    = vga_colour;
    plot_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          x_nxt    = sum_x[X_W-1:0];
          y_nxt    = sum_y[Y_W-1:0];
          c_nxt    = src_c;
          plot_nxt = in_bounds;
        end
      end
      DRAW: begin
        if (last) begin
          done_nxt = 1'b1;
        end else begin
          x_nxt    = sum_x[X_W-1:0];
          y_nxt    = sum_y[Y_W-1:0];
          c_nxt    = src_c;
          plot_nxt = in_bounds;
        end
      end
      default: ;
    endcase
  end

  // Output registers and the latched request, captured once per box
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      done       <= 1'b0;
      bx         <= '0;
      by         <= '0;
      col        <= '0;
    end else begin
      vga_x      <= x_nxt;
      vga_y      <= y_nxt;
      vga_colour <= c_nxt;
      vga_plot   <= plot_nxt;
      done       <= done_nxt;
      if (accept) begin
        bx  <= req_x;
        by  <= req_y;
        col <= req_color;
      end
    end
  end

endmodule
